hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Decode-stage RAW hazard interlock for the 5-stage pipeline. It tracks the destination registers of instructions in flight in Execute, Memory and Writeback using a 3-slot shifting scoreboard. It drives the pipeline's `PCWrite`, `DecodeWrite` and `controlMuxSignal` nets, which are currently tied to 1. On a hazard it freezes PC and Fetch_To_Decode and injects a bubble into Decode_To_Execute until the producer's value is readable from the register file.

## Interface
Parameters:
- `WB_BYPASS`, default 0: 1 = the register file returns a same-cycle Writeback write on read, so the WB slot never causes a stall; 0 = the WB slot stalls too.
- `CNT_W`, default 32: width of the statistics counters.

Ports:
- `Clk`  in  1  pipeline clock, rising edge.
- `Reset`  in  1  asynchronous, active-high.
- `Rs`  in  5  source register field `instructionDecode[25:21]`.
- `Rt`  in  5  source register field `instructionDecode[20:16]`.
- `UsesRs`  in  1  decode instruction reads rs (ALU, branch compare, jr, load/store base).
- `UsesRt`  in  1  decode instruction reads rt (R-type, branch compare, store data).
- `DecRegWrite`  in  1  un-bubbled RegWrite from Controller.
- `DecRd`  in  5  final destination after the RegDst/Jal muxes (`regDstOutput`).
- `PCWrite`  out  1  1 = PC advances.
- `DecodeWrite`  out  1  1 = Fetch_To_Decode loads.
- `controlMuxSignal`  out  1  1 = pass controls; 0 = zero all controls (bubble).
- `Stall`  out  1  hazard active this cycle; equals `~PCWrite`.
- `StallCycles`  out  `CNT_W`  present only with `HAZARD_STATS_EN`.
- `HazardEvents`  out  `CNT_W`  present only with `HAZARD_STATS_EN`.

## Operation
Scoreboard state:
- Three slots: EX, MEM, WB. Each slot holds `{valid, rd[4:0]}`.
- A slot is a producer iff `valid` is 1 and `rd` is not 0. Register 0 never causes a hazard.

Hazard detection:
- `hazRs = UsesRs & (Rs != 0) & (Rs matches any producer slot)`.
- `hazRt` is defined the same way using `UsesRt` and `Rt`.
- When `WB_BYPASS` is 1, the WB slot is excluded from matching.
- `Stall = hazRs | hazRt`.
- When `Stall` is 1: `PCWrite = DecodeWrite = controlMuxSignal = 0`. Otherwise all three are 1.

Per-clock shift:
- WB takes MEM, and MEM takes EX.
- EX takes `{DecRegWrite & (DecRd != 0), DecRd}` when not stalled, or `{0, 0}` (bubble) when stalled.

Other rules:
- The block has no forwarding. Every RAW dependency, including branch compare and jr in Decode, stalls until the producer leaves the excluded window.
- A single instruction's `UsesRs`/`UsesRt`/`DecRd` must stay stable while stalled. This holds because Fetch_To_Decode is frozen.

## Timing
- Outputs are combinational from the scoreboard registers and the decode inputs. They are valid in the same cycle the consumer sits in Decode.
- Stall length for a consumer immediately behind its producer: 3 cycles with `WB_BYPASS=0`, 2 cycles with `WB_BYPASS=1`. With one independent instruction between them: 2 and 1 cycles respectively.
- Reset, asynchronous: all slots become `{0, 0}`, giving `Stall=0`, `PCWrite=DecodeWrite=controlMuxSignal=1`, and counters 0.
- Reset asserted mid-stall clears the scoreboard immediately. The outputs return to 1 in the same cycle.
- Simultaneous rs and rt hazards on different slots: the stall persists until both clear.
- A producer in the same cycle as reset is dropped.
- Decode writing rd=0 never enters the scoreboard as a producer.

## Configuration
- `HAZARD_STATS_EN` defined: adds the `StallCycles` and `HazardEvents` ports.
  - `StallCycles` increments on every clock with `Stall=1`.
  - `HazardEvents` increments on each 0→1 rising edge of `Stall`. This uses a registered copy of the previous `Stall`, which resets to 0.
  - Both counters saturate at all-ones and clear on `Reset`.
- `HAZARD_STATS_EN` undefined: the counters, the edge register and both ports are absent. Hazard behaviour is identical.

## Test plan
- Reset with `UsesRs=1`, `Rs=5` → `Stall=0`, `PCWrite=1`, all slots empty.
- Cycle 0: `DecRegWrite=1`, `DecRd=8`. Cycle 1: `UsesRs=1`, `Rs=8`. With `WB_BYPASS=0` → `Stall=1` for exactly 3 cycles and the EX slot takes a bubble each of those cycles. With `WB_BYPASS=1` → 2 cycles.
- Producer with `DecRd=0`, then consumer `Rs=0` → no stall.
- Producer rd=9, then an independent instruction, then consumer `Rt=9` with `UsesRt=1` and `WB_BYPASS=0` → 2-cycle stall.
- Producer rd=4, then producer rd=6, then consumer with `Rs=4` and `Rt=6` → stall ends only when rd=6 leaves the last matched slot. Assert `Reset` in the middle of the stall → `PCWrite=1` immediately.
- With `HAZARD_STATS_EN`: two separate 3-cycle stalls → `StallCycles=6`, `HazardEvents=2`. With `CNT_W=2` → `StallCycles` holds at 3.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage RAW hazard interlock for the 5-stage pipeline. A 3-slot
//   shifting scoreboard (EX, MEM, WB) records the destination register of
//   every instruction in flight. When the instruction in Decode reads a
//   register that an in-flight instruction still has to write, PC and
//   Fetch_To_Decode are frozen and a bubble is injected into Decode_To_Execute.
//   There is no forwarding, so the stall lasts until the producer's value can
//   be read from the register file.
//
// Parameters
//   WB_BYPASS  1 = register file returns a same-cycle WB write on read, so the
//              WB slot never stalls; 0 = the WB slot stalls as well.
//   CNT_W      width of the statistics counters.
//
// Optional feature macro: HAZARD_STATS_EN
//   When defined, adds StallCycles / HazardEvents saturating counters.
//
// Ports
//   Clk               pipeline clock, rising edge
//   Reset             asynchronous, active-high
//   Rs, Rt            decode source register fields
//   UsesRs, UsesRt    decode instruction actually reads rs / rt
//   DecRegWrite       un-bubbled RegWrite from the controller
//   DecRd             final destination register (after RegDst/Jal muxes)
//   PCWrite           1 = PC advances
//   DecodeWrite       1 = Fetch_To_Decode loads
//   controlMuxSignal  1 = pass controls, 0 = bubble
//   Stall             hazard active this cycle (~PCWrite)
//   StallCycles       clocks spent stalled        (HAZARD_STATS_EN only)
//   HazardEvents      number of stall episodes    (HAZARD_STATS_EN only)

module hazard_scoreboard #(
  parameter int WB_BYPASS = 0,
  parameter int CNT_W     = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] Rs,
  input  logic [4:0] Rt,
  input  logic       UsesRs,
  input  logic       UsesRt,
  input  logic       DecRegWrite,
  input  logic [4:0] DecRd,
  output logic       PCWrite,
  output logic       DecodeWrite,
  output logic       controlMuxSignal,
  output logic       Stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] HazardEvents
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_scoreboard: CNT_W must be at least 1");
  end

  logic       r_ex_v;
  logic [4:0] r_ex_rd;
  logic       r_mem_v;
  logic [4:0] r_mem_rd;
  logic       r_wb_v;
  logic [4:0] r_wb_rd;

  logic w_ex_prod;
  logic w_mem_prod;
  logic w_wb_prod;
  logic w_haz_rs;
  logic w_haz_rt;
  logic w_stall;

  // Register 0 is hard-wired, so an entry writing it is never a producer.
  assign w_ex_prod  = r_ex_v  && (r_ex_rd  != 5'd0);
  assign w_mem_prod = r_mem_v && (r_mem_rd != 5'd0);
  // With the write-through register file the WB value is already readable.
  assign w_wb_prod  = (WB_BYPASS == 0) && r_wb_v && (r_wb_rd != 5'd0);

  assign w_haz_rs = UsesRs && (Rs != 5'd0) &&
                    ((w_ex_prod  && (Rs == r_ex_rd))  ||
                     (w_mem_prod && (Rs == r_mem_rd)) ||
                     (w_wb_prod  && (Rs == r_wb_rd)));

  assign w_haz_rt = UsesRt && (Rt != 5'd0) &&
                    ((w_ex_prod  && (Rt == r_ex_rd))  ||
                     (w_mem_prod && (Rt == r_mem_rd)) ||
                     (w_wb_prod  && (Rt == r_wb_rd)));

  assign w_stall = w_haz_rs || w_haz_rt;

  assign Stall            = w_stall;
  assign PCWrite          = ~w_stall;
  assign DecodeWrite      = ~w_stall;
  assign controlMuxSignal = ~w_stall;

  // Shift every clock; a stalled Decode instruction enters EX as a bubble so
  // it is recorded only once, on the cycle it actually leaves Decode.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ex_v   <= 1'b0;
      r_ex_rd  <= 5'd0;
      r_mem_v  <= 1'b0;
      r_mem_rd <= 5'd0;
      r_wb_v   <= 1'b0;
      r_wb_rd  <= 5'd0;
    end else begin
      r_wb_v   <= r_mem_v;
      r_wb_rd  <= r_mem_rd;
      r_mem_v  <= r_ex_v;
      r_mem_rd <= r_ex_rd;
      if (w_stall) begin
        r_ex_v  <= 1'b0;
        r_ex_rd <= 5'd0;
      end else begin
        r_ex_v  <= DecRegWrite && (DecRd != 5'd0);
        r_ex_rd <= DecRd;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_stall_q;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_hazard_events;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_stall_q       <= 1'b0;
      r_stall_cycles  <= '0;
      r_hazard_events <= '0;
    end else begin
      r_stall_q <= w_stall;
      if (w_stall && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + CNT_ONE;
      end
      // New episode = Stall rising relative to the previous clock.
      if (w_stall && !r_stall_q && !(&r_hazard_events)) begin
        r_hazard_events <= r_hazard_events + CNT_ONE;
      end
    end
  end

  assign StallCycles  = r_stall_cycles;
  assign HazardEvents = r_hazard_events;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard. Two instances share the decode
// inputs: u_nb (WB_BYPASS=0) and u_b (WB_BYPASS=1). With HAZARD_STATS_EN a
// third instance u_sat (CNT_W=2) exercises counter saturation.

module tb_hazard_scoreboard;

  logic       Clk;
  logic       Reset;
  logic [4:0] Rs;
  logic [4:0] Rt;
  logic       UsesRs;
  logic       UsesRt;
  logic       DecRegWrite;
  logic [4:0] DecRd;

  logic pcw_nb, dw_nb, cm_nb, stall_nb;
  logic pcw_b,  dw_b,  cm_b,  stall_b;

  int checks = 0;
  int errors = 0;

`ifdef HAZARD_STATS_EN
  logic [31:0] sc_nb, he_nb, sc_b, he_b;
  logic [1:0]  sc_sat, he_sat;
  logic        pcw_s, dw_s, cm_s, stall_s;
`endif

  hazard_scoreboard #(.WB_BYPASS(0), .CNT_W(32)) u_nb (
    .Clk(Clk), .Reset(Reset), .Rs(Rs), .Rt(Rt), .UsesRs(UsesRs), .UsesRt(UsesRt),
    .DecRegWrite(DecRegWrite), .DecRd(DecRd),
    .PCWrite(pcw_nb), .DecodeWrite(dw_nb), .controlMuxSignal(cm_nb), .Stall(stall_nb)
`ifdef HAZARD_STATS_EN
    , .StallCycles(sc_nb), .HazardEvents(he_nb)
`endif
  );

  hazard_scoreboard #(.WB_BYPASS(1), .CNT_W(32)) u_b (
    .Clk(Clk), .Reset(Reset), .Rs(Rs), .Rt(Rt), .UsesRs(UsesRs), .UsesRt(UsesRt),
    .DecRegWrite(DecRegWrite), .DecRd(DecRd),
    .PCWrite(pcw_b), .DecodeWrite(dw_b), .controlMuxSignal(cm_b), .Stall(stall_b)
`ifdef HAZARD_STATS_EN
    , .StallCycles(sc_b), .HazardEvents(he_b)
`endif
  );

`ifdef HAZARD_STATS_EN
  hazard_scoreboard #(.WB_BYPASS(0), .CNT_W(2)) u_sat (
    .Clk(Clk), .Reset(Reset), .Rs(Rs), .Rt(Rt), .UsesRs(UsesRs), .UsesRt(UsesRt),
    .DecRegWrite(DecRegWrite), .DecRd(DecRd),
    .PCWrite(pcw_s), .DecodeWrite(dw_s), .controlMuxSignal(cm_s), .Stall(stall_s),
    .StallCycles(sc_sat), .HazardEvents(he_sat)
  );
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one Decode cycle, check both instances mid-cycle, advance to the
  // next cycle (ends 1 time unit after the rising edge).
  task automatic cyc(input string tag,
                     input logic urs, input logic [4:0] rs,
                     input logic urt, input logic [4:0] rt,
                     input logic rw,  input logic [4:0] rd,
                     input logic exp_nb, input logic exp_b);
    UsesRs = urs; Rs = rs; UsesRt = urt; Rt = rt;
    DecRegWrite = rw; DecRd = rd;
    #4;
    chk({tag, "/stall_nb"}, {31'd0, stall_nb}, {31'd0, exp_nb});
    chk({tag, "/ctl_nb"}, {29'd0, pcw_nb, dw_nb, cm_nb}, {29'd0, {3{~exp_nb}}});
    chk({tag, "/stall_b"}, {31'd0, stall_b}, {31'd0, exp_b});
    chk({tag, "/ctl_b"}, {29'd0, pcw_b, dw_b, cm_b}, {29'd0, {3{~exp_b}}});
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 0, 5'd0, 0, 5'd0, 0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with a would-be consumer present; scoreboard must be empty.
    Reset = 1'b1;
    UsesRs = 1'b1; Rs = 5'd5; UsesRt = 1'b0; Rt = 5'd0;
    DecRegWrite = 1'b0; DecRd = 5'd0;
    #2;
    chk("rst/stall_nb", {31'd0, stall_nb}, 32'd0);
    chk("rst/pcw_nb", {31'd0, pcw_nb}, 32'd1);
    chk("rst/stall_b", {31'd0, stall_b}, 32'd0);
    chk("rst/pcw_b", {31'd0, pcw_b}, 32'd1);
`ifdef HAZARD_STATS_EN
    chk("rst/sc", sc_nb, 32'd0);
    chk("rst/he", he_nb, 32'd0);
`endif
    // Producer presented while reset is held is dropped.
    DecRegWrite = 1'b1; DecRd = 5'd12;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    cyc("rstdrop", 1, 5'd12, 0, 5'd0, 0, 5'd0, 1'b0, 1'b0);
    idle(3);

    // Adjacent producer/consumer; consumer itself writes r10.
    cyc("A/prod", 0, 5'd0, 0, 5'd0, 1, 5'd8, 1'b0, 1'b0);
    cyc("A/c1", 1, 5'd8, 0, 5'd0, 1, 5'd10, 1'b1, 1'b1);
    cyc("A/c2", 1, 5'd8, 0, 5'd0, 1, 5'd10, 1'b1, 1'b1);
    cyc("A/c3", 1, 5'd8, 0, 5'd0, 1, 5'd10, 1'b1, 1'b0);
    cyc("A/c4", 1, 5'd8, 0, 5'd0, 1, 5'd10, 1'b0, 1'b0);
    // Reader of r10: stall length shows r10 entered the scoreboard only after
    // the consumer left Decode (bubbles were injected while it was stalled).
    cyc("A/r1", 1, 5'd10, 0, 5'd0, 0, 5'd0, 1'b1, 1'b1);
    cyc("A/r2", 1, 5'd10, 0, 5'd0, 0, 5'd0, 1'b1, 1'b1);
    cyc("A/r3", 1, 5'd10, 0, 5'd0, 0, 5'd0, 1'b1, 1'b0);
    cyc("A/r4", 1, 5'd10, 0, 5'd0, 0, 5'd0, 1'b0, 1'b0);
    idle(3);
`ifdef HAZARD_STATS_EN
    chk("stats/sc_nb", sc_nb, 32'd6);
    chk("stats/he_nb", he_nb, 32'd2);
    chk("stats/sc_b", sc_b, 32'd4);
    chk("stats/he_b", he_b, 32'd2);
    chk("stats/sc_sat", {30'd0, sc_sat}, 32'd3);
    chk("stats/he_sat", {30'd0, he_sat}, 32'd2);
`endif

    // rd=0 producer and non-writing producer never stall.
    cyc("B/prod0", 0, 5'd0, 0, 5'd0, 1, 5'd0, 1'b0, 1'b0);
    cyc("B/cons0", 1, 5'd0, 1, 5'd0, 0, 5'd0, 1'b0, 1'b0);
    cyc("B/nowr", 0, 5'd0, 0, 5'd0, 0, 5'd7, 1'b0, 1'b0);
    cyc("B/cons7", 1, 5'd7, 1, 5'd7, 0, 5'd0, 1'b0, 1'b0);
    // UsesRs=0 masks a match.
    cyc("B/prod3", 0, 5'd0, 0, 5'd0, 1, 5'd3, 1'b0, 1'b0);
    cyc("B/nouse", 0, 5'd3, 0, 5'd3, 0, 5'd0, 1'b0, 1'b0);
    idle(3);

    // One independent instruction between producer and rt consumer.
    cyc("C/prod", 0, 5'd0, 0, 5'd0, 1, 5'd9, 1'b0, 1'b0);
    cyc("C/indep", 1, 5'd2, 0, 5'd0, 0, 5'd0, 1'b0, 1'b0);
    cyc("C/c1", 1, 5'd3, 1, 5'd9, 0, 5'd0, 1'b1, 1'b1);
    cyc("C/c2", 1, 5'd3, 1, 5'd9, 0, 5'd0, 1'b1, 1'b0);
    cyc("C/c3", 1, 5'd3, 1, 5'd9, 0, 5'd0, 1'b0, 1'b0);
    idle(3);

    // Two producers, rs and rt hazards on different slots; reset mid-stall.
    cyc("D/p4", 0, 5'd0, 0, 5'd0, 1, 5'd4, 1'b0, 1'b0);
    cyc("D/p6", 0, 5'd0, 0, 5'd0, 1, 5'd6, 1'b0, 1'b0);
    cyc("D/c1", 1, 5'd4, 1, 5'd6, 0, 5'd0, 1'b1, 1'b1);
    cyc("D/c2", 1, 5'd4, 1, 5'd6, 0, 5'd0, 1'b1, 1'b1);
    #2;
    chk("D/c3/stall_nb", {31'd0, stall_nb}, 32'd1);
    chk("D/c3/stall_b", {31'd0, stall_b}, 32'd0);
    Reset = 1'b1;
    #2;
    chk("D/rst/stall_nb", {31'd0, stall_nb}, 32'd0);
    chk("D/rst/ctl_nb", {29'd0, pcw_nb, dw_nb, cm_nb}, 32'd7);
    chk("D/rst/stall_b", {31'd0, stall_b}, 32'd0);
`ifdef HAZARD_STATS_EN
    chk("D/rst/sc", sc_nb, 32'd0);
    chk("D/rst/he", he_nb, 32'd0);
`endif
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    cyc("D/after", 1, 5'd4, 1, 5'd6, 0, 5'd0, 1'b0, 1'b0);

    // Full rs+rt overlap without reset: stall ends when r6 leaves WB (nb).
    cyc("E/p4", 0, 5'd0, 0, 5'd0, 1, 5'd4, 1'b0, 1'b0);
    cyc("E/p6", 0, 5'd0, 0, 5'd0, 1, 5'd6, 1'b0, 1'b0);
    cyc("E/c1", 1, 5'd4, 1, 5'd6, 0, 5'd0, 1'b1, 1'b1);
    cyc("E/c2", 1, 5'd4, 1, 5'd6, 0, 5'd0, 1'b1, 1'b1);
    cyc("E/c3", 1, 5'd4, 1, 5'd6, 0, 5'd0, 1'b1, 1'b0);
    cyc("E/c4", 1, 5'd4, 1, 5'd6, 0, 5'd0, 1'b0, 1'b0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
